// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM clock time-setting logic.
//   state_t      : edit FSM states (ST_RUN, ST_SET_HOUR, ST_SET_MIN, ST_COMMIT)
//   HOUR_MAX     : largest legal hour value (23)
//   MINUTE_MAX   : largest legal minute value (59)
//   FIELD_*      : edit_field output codes
//   hour_inc / minute_inc : wrapping increment helpers
//   hour_clamp / minute_clamp : force out-of-range captures to 0
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [5:0] MINUTE_MAX = 6'd59;

  localparam logic [1:0] FIELD_NONE   = 2'd0;
  localparam logic [1:0] FIELD_HOUR   = 2'd1;
  localparam logic [1:0] FIELD_MINUTE = 2'd2;

  // Wrap is decided before the add, so the result never leaves 0..HOUR_MAX.
  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h >= HOUR_MAX) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] minute_inc(input logic [5:0] m);
    return (m >= MINUTE_MAX) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [4:0] hour_clamp(input logic [4:0] h);
    return (h > HOUR_MAX) ? 5'd0 : h;
  endfunction

  function automatic logic [5:0] minute_clamp(input logic [5:0] m);
    return (m > MINUTE_MAX) ? 6'd0 : m;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, sampling on a shared tick,
// two-sample agreement filter and rising-edge press pulse.
// Ports:
//   clock     in  system clock
//   reset     in  asynchronous active-low reset
//   tick      in  one-cycle sample strobe from the shared prescaler
//   btn_raw   in  raw button, active-high, asynchronous to clock
//   press     out one-cycle pulse on debounced 0->1
//   hold_tick out high on a tick where the button is confirmed still held
module button_debounce (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic press,
  output logic hold_tick
);

  logic sync_0;
  logic sync_1;
  logic sample;
  logic level;
  logic level_q;
  // Cleared by reset and set only once the button has been seen settled low,
  // so a button held through reset cannot produce a press until released.
  logic armed;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_0  <= 1'b0;
      sync_1  <= 1'b0;
      sample  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sync_0  <= btn_raw;
      sync_1  <= sync_0;
      level_q <= level;
      if (tick) begin
        sample <= sync_1;
        if (sync_1 == sample) begin
          level <= sync_1;
          if (!sync_1) begin
            armed <= 1'b1;
          end
        end
      end
    end
  end

  assign press     = level & ~level_q & armed;
  // Two agreeing high samples: true on the tick the level rises and on every
  // later tick while the button stays down.
  assign hold_tick = tick & sync_1 & sample & armed;

endmodule

// File: rtl/clock_time_setter.sv
// Time-setting front end for the HH:MM clock. Debounces the mode and
// increment buttons, freezes the clock while a shadow hour/minute is edited,
// then commits it with a one-cycle load strobe.
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-low reset
//   btn_mode    in   raw mode button
//   btn_inc     in   raw increment button
//   cur_hour    in   live hour (0..23)
//   cur_minute  in   live minute (0..59)
//   run_flag    out  1 = clock runs, 0 while editing/committing
//   load        out  one-cycle commit strobe
//   load_hour   out  shadow hour
//   load_minute out  shadow minute
//   edit_field  out  0 none, 1 hour, 2 minute
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS = 16,
  parameter int unsigned REPEAT_TICKS  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  output logic       run_flag,
  output logic       load,
  output logic [4:0] load_hour,
  output logic [5:0] load_minute,
  output logic [1:0] edit_field
);

  localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [DEBOUNCE_BITS-1:0] PRESC_ONE = DEBOUNCE_BITS'(1);
  localparam logic [REP_W-1:0]         REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0]         REP_LAST  = REP_W'(REPEAT_TICKS);

  // Shared sample tick for both buttons.
  logic [DEBOUNCE_BITS-1:0] presc;
  logic                     tick;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_ONE;
    end
  end

  assign tick = (presc == '1);

  logic mode_press;
  logic mode_hold_unused;
  logic inc_press;
  logic inc_hold;

  button_debounce u_mode_db (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .btn_raw   (btn_mode),
    .press     (mode_press),
    .hold_tick (mode_hold_unused)
  );

  button_debounce u_inc_db (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .btn_raw   (btn_inc),
    .press     (inc_press),
    .hold_tick (inc_hold)
  );

  // Auto-repeat: the counter includes the tick on which the press was
  // recognised, so the first repeat lands REPEAT_TICKS ticks after the press
  // and subsequent ones every REPEAT_TICKS ticks while still held.
  logic [REP_W-1:0] rep_cnt;
  logic             rep_pulse;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_cnt   <= '0;
      rep_pulse <= 1'b0;
    end else begin
      rep_pulse <= 1'b0;
      if (tick) begin
        if (!inc_hold) begin
          rep_cnt <= '0;
        end else if (rep_cnt == REP_LAST) begin
          rep_cnt   <= REP_ONE;
          rep_pulse <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + REP_ONE;
        end
      end
    end
  end

  logic inc_evt;
  assign inc_evt = inc_press | rep_pulse;

  state_t     state;
  logic [4:0] shadow_hour;
  logic [5:0] shadow_minute;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_RUN;
      shadow_hour   <= '0;
      shadow_minute <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mode_press) begin
            shadow_hour   <= hour_clamp(cur_hour);
            shadow_minute <= minute_clamp(cur_minute);
            state         <= ST_SET_HOUR;
          end
        end
        ST_SET_HOUR: begin
          if (mode_press) begin
            state <= ST_SET_MIN;
          end else if (inc_evt) begin
            shadow_hour <= hour_inc(shadow_hour);
          end
        end
        ST_SET_MIN: begin
          if (mode_press) begin
            state <= ST_COMMIT;
          end else if (inc_evt) begin
            shadow_minute <= minute_inc(shadow_minute);
          end
        end
        ST_COMMIT: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    run_flag   = 1'b0;
    load       = 1'b0;
    edit_field = FIELD_NONE;
    case (state)
      ST_RUN:      run_flag   = 1'b1;
      ST_SET_HOUR: edit_field = FIELD_HOUR;
      ST_SET_MIN:  edit_field = FIELD_MINUTE;
      ST_COMMIT:   load       = 1'b1;
      default:     run_flag   = 1'b1;
    endcase
  end

  assign load_hour   = shadow_hour;
  assign load_minute = shadow_minute;

endmodule

// File: tb/tb_clock_time_setter.sv
`timescale 1ns/1ps
module tb_clock_time_setter;

  localparam int TICK = 16;  // 2**DEBOUNCE_BITS with DEBOUNCE_BITS=4
  localparam int RT   = 3;   // REPEAT_TICKS

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_minute = '0;
  logic       run_flag;
  logic       load;
  logic [4:0] load_hour;
  logic [5:0] load_minute;
  logic [1:0] edit_field;

  clock_time_setter #(
    .DEBOUNCE_BITS (4),
    .REPEAT_TICKS  (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .cur_hour    (cur_hour),
    .cur_minute  (cur_minute),
    .run_flag    (run_flag),
    .load        (load),
    .load_hour   (load_hour),
    .load_minute (load_minute),
    .edit_field  (edit_field)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Model: field 0 = running, 1 = editing hour, 2 = editing minute.
  int exp_field = 0;
  int exp_hour = 0;
  int exp_min = 0;
  bit model_valid = 1'b0;
  int exp_loads = 0;
  int seen_loads = 0;
  int exp_load_h = 0;
  int exp_load_m = 0;
  int last_load_h = -1;
  int last_load_m = -1;
  bit load_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Increments produced by holding inc for exactly n sample ticks: the
  // debounced level needs two agreeing samples, then one repeat per RT
  // further held ticks.
  function automatic int incs_for_ticks(input int n);
    if (n < 2) return 0;
    return 1 + (n - 2) / RT;
  endfunction

  function automatic int clamp(input int v, input int maxv);
    return (v > maxv) ? 0 : v;
  endfunction

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      check("hour_range", int'(load_hour <= 5'd23), 1);
      check("minute_range", int'(load_minute <= 6'd59), 1);
      check("run_flag_vs_field", int'(run_flag), int'(edit_field == 2'd0 && !load));
      if (load) begin
        seen_loads++;
        check("load_width", int'(load_prev), 0);
        check("load_hour_at_load", int'(load_hour), exp_load_h);
        check("load_minute_at_load", int'(load_minute), exp_load_m);
        last_load_h = int'(load_hour);
        last_load_m = int'(load_minute);
      end
      load_prev = load;
      if (model_valid) begin
        check("run_flag", int'(run_flag), int'(exp_field == 0));
        check("edit_field", int'(edit_field), exp_field);
        check("load_idle", int'(load), 0);
        check("shadow_hour", int'(load_hour), exp_hour);
        check("shadow_minute", int'(load_minute), exp_min);
      end
    end else begin
      load_prev = 1'b0;
    end
  end

  // Press mode and/or inc for 'hold' cycles, release, let everything settle,
  // then advance the model.
  task automatic press(input bit m, input bit i, input int hold);
    model_valid = 1'b0;
    if (m && exp_field == 2) begin
      exp_load_h = exp_hour;
      exp_load_m = exp_min;
    end
    @(posedge clock); #1;
    btn_mode = m;
    btn_inc  = i;
    repeat (hold) @(posedge clock);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (64) @(posedge clock);
    #1;
    if (m) begin
      case (exp_field)
        0: begin
          exp_hour  = clamp(int'(cur_hour), 23);
          exp_min   = clamp(int'(cur_minute), 59);
          exp_field = 1;
        end
        1: exp_field = 2;
        default: begin
          exp_field = 0;
          exp_loads++;
        end
      endcase
    end else if (i) begin
      if (exp_field == 1) exp_hour = (exp_hour + incs_for_ticks(hold / TICK)) % 24;
      if (exp_field == 2) exp_min  = (exp_min + incs_for_ticks(hold / TICK)) % 60;
    end
    model_valid = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with mode held: no press until a fresh 0->1 edge.
    btn_mode = 1'b1;
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_run_flag", int'(run_flag), 1);
    check("rst_load", int'(load), 0);
    check("rst_load_hour", int'(load_hour), 0);
    check("rst_load_minute", int'(load_minute), 0);
    check("rst_edit_field", int'(edit_field), 0);
    model_valid = 1'b1;
    repeat (120) @(posedge clock);
    #1;
    btn_mode = 1'b0;
    repeat (80) @(posedge clock);
    #1;
    check("held_mode_no_press", int'(edit_field), 0);

    // 23:59 capture, hour wrap, glitch rejection, minute wrap, commit 0:00.
    cur_hour = 5'd23;
    cur_minute = 6'd59;
    press(1, 0, 64);
    check("capture_hour_23", int'(load_hour), 23);
    check("capture_field_hour", int'(edit_field), 1);
    press(0, 1, 5);
    check("glitch_no_change", int'(load_hour), 23);
    press(0, 1, 60);
    check("hour_wrap_to_0", int'(load_hour), 0);
    press(1, 0, 64);
    press(0, 1, 64);
    check("minute_wrap_to_0", int'(load_minute), 0);
    press(1, 0, 64);
    check("commit1_count", seen_loads, 1);
    check("commit1_hour", last_load_h, 0);
    check("commit1_minute", last_load_m, 0);
    check("commit1_run_flag", int'(run_flag), 1);

    // Auto-repeat: 16 ticks held from minute 10.
    cur_hour = 5'd5;
    cur_minute = 6'd10;
    press(1, 0, 64);
    press(1, 0, 64);
    press(0, 1, 16 * TICK);
    check("repeat_minute_15", int'(load_minute), 15);
    repeat (100) @(posedge clock);
    #1;
    check("repeat_stops", int'(load_minute), 15);
    press(1, 0, 64);
    check("commit2_hour", last_load_h, 5);
    check("commit2_minute", last_load_m, 15);

    // inc ignored while running.
    press(0, 1, 64);
    check("run_inc_ignored", int'(load_minute), 15);

    // Mode and inc together: mode wins.
    cur_hour = 5'd7;
    cur_minute = 6'd20;
    press(1, 0, 64);
    press(1, 1, 64);
    check("simul_field_min", int'(edit_field), 2);
    check("simul_hour_kept", int'(load_hour), 7);
    press(1, 0, 64);

    // Out-of-range capture clamps to 0.
    cur_hour = 5'd30;
    cur_minute = 6'd61;
    press(1, 0, 64);
    check("clamp_hour", int'(load_hour), 0);
    check("clamp_minute", int'(load_minute), 0);
    press(1, 0, 64);
    press(1, 0, 64);

    // Reset mid-edit in SET_MIN with 12:34: no load, back to RUN.
    cur_hour = 5'd12;
    cur_minute = 6'd34;
    press(1, 0, 64);
    press(1, 0, 64);
    check("pre_reset_hour", int'(load_hour), 12);
    check("pre_reset_minute", int'(load_minute), 34);
    check("pre_reset_field", int'(edit_field), 2);
    @(negedge clock); #2;
    model_valid = 1'b0;
    reset = 1'b0;
    exp_field = 0;
    exp_hour = 0;
    exp_min = 0;
    #1;
    check("midreset_run_flag", int'(run_flag), 1);
    check("midreset_field", int'(edit_field), 0);
    check("midreset_load", int'(load), 0);
    check("midreset_hour", int'(load_hour), 0);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    model_valid = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    check("load_count_total", seen_loads, exp_loads);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
